ww_arith_seq: RTL
=================

Name: ww_arith_seq

Overview:
- Step sequencer for the Whirlwind arithmetic element.
- Decoded SL, SR, MR, MH and DV orders arrive as a start pulse plus op code and count; the block issues one-cycle control pulses (shift, add-step, divide-step, round, sign prep and fix) to the AC/BR/AR datapath.
- Reports completion, or a divide-overflow alarm, to the central control.
- Pure control: it holds no data words.

Parameters:
- MUL_STEPS, 15: number of add/shift iterations for MR/MH (magnitude bits).
- DIV_STEPS, 16: number of divide/shift iterations for DV.
- CNT_W, 6: width of the step counter and count input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle order strobe; sampled only in IDLE.
- op  in  3  order select: 0 SL, 1 SR, 2 MR, 3 MH, 4 DV; 5-7 illegal.
- count  in  CNT_W  shift count for SL/SR (address bits 5:0); ignored for other ops.
- stop  in  1  synchronous abort from the stop/clear switches.
- div_ovf  in  1  datapath compare result, |AC| >= |AR|; valid during PREP of a DV.
- busy  out  1  high from the cycle after start through the DONE cycle.
- shl  out  1  shift AC:BR left one place.
- shr  out  1  shift AC:BR right one place.
- mul_add  out  1  add AR into AC if BR lsb is 1.
- div_step  out  1  divide trial subtract/add and quotient bit.
- rnd  out  1  round AC from BR msb.
- sign_prep  out  1  convert operands to magnitudes and latch the result sign.
- sign_fix  out  1  apply the latched sign to the result.
- done  out  1  one-cycle completion pulse.
- alarm  out  1  one-cycle divide-overflow alarm, coincident with done.

Behaviour:
- **Encoding:** all outputs are registered and one-hot in time: at most one of shl, shr, mul_add, div_step, rnd, sign_prep, sign_fix is high in any cycle.
- **Reset:** reset asserted forces IDLE immediately. All outputs go to 0 and the counter clears, including mid-operation. No done is issued for an order cut off by reset.
- **States:** IDLE, SHIFT, ADD, PREP, ROUND, FIX, DONE.
- **Timing origin:** cycle 0 is the edge that samples start=1 in IDLE. Latencies below are counted from that edge.
- **SL, count n:** shl high in cycles 1..n; done in cycle n+1.
  - n=0: done in cycle 1, no shl.
  - Counts 32-63 are executed in full, with no saturation.
- **SR, count n:** shr in cycles 1..n, rnd in cycle n+1, done in cycle n+2.
  - n=0 still issues rnd in cycle 1; done in cycle 2.
- **MH:**
  - sign_prep in cycle 1.
  - Then MUL_STEPS iterations of (mul_add, shr) in alternating cycles, occupying cycles 2..31.
  - sign_fix in cycle 32; done in cycle 33.
- **MR:** as MH, with rnd inserted in cycle 32, sign_fix in 33, done in 34.
- **DV:**
  - sign_prep in cycle 1; div_ovf is sampled on the edge ending cycle 1.
  - If div_ovf=1: done and alarm together in cycle 2, and no further step pulses.
  - Otherwise: DIV_STEPS iterations of (div_step, shl) occupying cycles 2..33, sign_fix in 34, done in 35.
- **Illegal op:** done and alarm in cycle 1, with no step pulses.
- **Start while busy:** ignored, with no effect on the current order.
- **Start in the DONE cycle:** ignored; a new order is accepted from the following cycle.
- **Stop:** stop=1 sampled in any non-IDLE state returns to IDLE on that edge. The current cycle's pulse still completes. No done or alarm is issued and busy falls the next cycle. stop in IDLE has no effect.
- **stop and start together in IDLE:** stop wins, and the start is dropped.
- **Counter:** the count is latched at start; later changes to count or op are ignored. The counter decrements per completed shift or iteration and never wraps below 0.

Test Plan:
- Reset, then SL with count 'o40 (order 'o154040) -> shl high for exactly 32 consecutive cycles 1..32; done in cycle 33; busy high for cycles 1..33; no other pulses.
- SR with count 3 -> shr in cycles 1-3, rnd in cycle 4, done in cycle 5; SR with count 0 -> rnd in cycle 1, done in cycle 2.
- MH, then MR -> sign_prep in cycle 1; 15 mul_add pulses at cycles 2,4,...,30, each followed by shr; sign_fix in cycle 32 (MH) or rnd at 32 and sign_fix at 33 (MR); done in cycle 33 or 34; no overlap between any two pulse outputs.
- DV with div_ovf=0 -> 16 div_step/shl pairs over cycles 2..33, sign_fix in 34, done in 35, alarm 0. DV with div_ovf=1 -> done and alarm both in cycle 2, and no div_step.
- Abort cases:
  - stop asserted in cycle 10 of MH -> returns to IDLE, no done, busy low from cycle 11.
  - Async reset asserted mid-DV -> all outputs 0 immediately, without waiting for a clock edge.
  - A subsequent SL 2 -> executes normally.
- Start pulses in cycles 5 and 20 of an SL 31 -> both ignored, with done still in cycle 32. Illegal op 6 -> done and alarm in cycle 1.

Source files
------------

// File: rtl/ww_arith_seq.sv
// Whirlwind arithmetic element step sequencer: turns decoded SL/SR/MR/MH/DV
// orders into one-cycle datapath control pulses and a completion/alarm report.
module ww_arith_seq #(
  parameter int MUL_STEPS = 15,
  parameter int DIV_STEPS = 16,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             stop,
  input  logic             div_ovf,
  output logic             busy,
  output logic             shl,
  output logic             shr,
  output logic             mul_add,
  output logic             div_step,
  output logic             rnd,
  output logic             sign_prep,
  output logic             sign_fix,
  output logic             done,
  output logic             alarm
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_ADD   = 3'd2,
    S_PREP  = 3'd3,
    S_ROUND = 3'd4,
    S_FIX   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] OP_SL = 3'd0;
  localparam logic [2:0] OP_SR = 3'd1;
  localparam logic [2:0] OP_MR = 3'd2;
  localparam logic [2:0] OP_MH = 3'd3;
  localparam logic [2:0] OP_DV = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_STEPS);

  state_t           state_r;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;

  // State names the pulse being driven in the current cycle; cnt_r holds the
  // shifts or iterations still owed after that pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      op_r      <= OP_SL;
      cnt_r     <= CNT_ZERO;
      busy      <= 1'b0;
      shl       <= 1'b0;
      shr       <= 1'b0;
      mul_add   <= 1'b0;
      div_step  <= 1'b0;
      rnd       <= 1'b0;
      sign_prep <= 1'b0;
      sign_fix  <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      busy      <= 1'b1;
      shl       <= 1'b0;
      shr       <= 1'b0;
      mul_add   <= 1'b0;
      div_step  <= 1'b0;
      rnd       <= 1'b0;
      sign_prep <= 1'b0;
      sign_fix  <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      if (stop && (state_r != S_IDLE)) begin
        state_r <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start && !stop) begin
              op_r <= op;
              case (op)
                OP_SL: begin
                  if (count == CNT_ZERO) begin
                    state_r <= S_DONE;
                    done    <= 1'b1;
                  end else begin
                    state_r <= S_SHIFT;
                    shl     <= 1'b1;
                    cnt_r   <= count - CNT_ONE;
                  end
                end
                OP_SR: begin
                  if (count == CNT_ZERO) begin
                    state_r <= S_ROUND;
                    rnd     <= 1'b1;
                  end else begin
                    state_r <= S_SHIFT;
                    shr     <= 1'b1;
                    cnt_r   <= count - CNT_ONE;
                  end
                end
                OP_MR, OP_MH: begin
                  state_r   <= S_PREP;
                  sign_prep <= 1'b1;
                  cnt_r     <= CNT_MUL;
                end
                OP_DV: begin
                  state_r   <= S_PREP;
                  sign_prep <= 1'b1;
                  cnt_r     <= CNT_DIV;
                end
                default: begin
                  state_r <= S_DONE;
                  done    <= 1'b1;
                  alarm   <= 1'b1;
                end
              endcase
            end else begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          S_SHIFT: begin
            if ((op_r == OP_SL) || (op_r == OP_SR)) begin
              if (cnt_r == CNT_ZERO) begin
                if (op_r == OP_SL) begin
                  state_r <= S_DONE;
                  done    <= 1'b1;
                end else begin
                  state_r <= S_ROUND;
                  rnd     <= 1'b1;
                end
              end else begin
                state_r <= S_SHIFT;
                shl     <= (op_r == OP_SL);
                shr     <= (op_r == OP_SR);
                cnt_r   <= cnt_r - CNT_ONE;
              end
            end else if (cnt_r == CNT_ZERO) begin
              case (op_r)
                OP_MR: begin
                  state_r <= S_ROUND;
                  rnd     <= 1'b1;
                end
                default: begin
                  state_r  <= S_FIX;
                  sign_fix <= 1'b1;
                end
              endcase
            end else begin
              state_r  <= S_ADD;
              mul_add  <= (op_r != OP_DV);
              div_step <= (op_r == OP_DV);
            end
          end
          S_ADD: begin
            // Second half of an iteration: multiply shifts right, divide left.
            state_r <= S_SHIFT;
            shl     <= (op_r == OP_DV);
            shr     <= (op_r != OP_DV);
            if (cnt_r != CNT_ZERO) begin
              cnt_r <= cnt_r - CNT_ONE;
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          S_PREP: begin
            if ((op_r == OP_DV) && div_ovf) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              alarm   <= 1'b1;
            end else begin
              state_r  <= S_ADD;
              mul_add  <= (op_r != OP_DV);
              div_step <= (op_r == OP_DV);
            end
          end
          S_ROUND: begin
            if (op_r == OP_MR) begin
              state_r  <= S_FIX;
              sign_fix <= 1'b1;
            end else begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end
          end
          S_FIX: begin
            state_r <= S_DONE;
            done    <= 1'b1;
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
